// File: rtl/keyhash_pkg.sv
// keyhash_pkg -- shared constants and helpers for the key-hash FWFT FIFO.
//   KEY_W                 : native key width (default FIFO word width)
//   DEFAULT_DEPTH         : default FIFO depth in words
//   DEFAULT_AEMPTY_TH     : default almost_empty threshold (count <= TH)
//   DEFAULT_AFULL_MARGIN  : almost_full fires this many words below DEPTH
//   fifo_op_e             : accepted-operation encoding {write, read}
//   clog2()               : ceiling log2 usable in parameter expressions
package keyhash_pkg;

  localparam int KEY_W                = 128;
  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_AEMPTY_TH    = 2;
  localparam int DEFAULT_AFULL_MARGIN = 2;

  // Bit 1 = accepted write, bit 0 = accepted read.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keyhash_fifo_ram.sv
// keyhash_fifo_ram -- simple dual-port storage for the FIFO body.
// One write port and one read port on the same clock; the read data is
// registered (one-cycle latency) and returns the old contents on a
// same-address read/write collision, which maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (sampled every cycle)
//   rd_data : registered read data, mem[rd_addr] from the previous edge
module keyhash_fifo_ram #(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 15,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/keyhash_fwft_fifo.sv
// keyhash_fwft_fifo -- first-word-fall-through FIFO for hash keys.
// The head word lives in an output register (dout); the other DEPTH-1
// words live in keyhash_fifo_ram, addressed by wrap-around pointers.
//   clk, rst_n      : clock, synchronous active-low reset
//   wr_en, din      : write request and data (dropped while full)
//   rd_en           : acknowledge of the word on dout (ignored while empty)
//   dout            : head word, valid whenever empty=0
//   full, empty     : count == DEPTH / count == 0
//   almost_full     : count >= AFULL_TH
//   almost_empty    : count <= AEMPTY_TH
//   count           : words held including the head word
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
//   err_clr         : clears the sticky flags (a same-cycle new error wins)
module keyhash_fwft_fifo
  import keyhash_pkg::*;
#(
  parameter int DATA_W    = KEY_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - DEFAULT_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEFAULT_AEMPTY_TH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int AW        = clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int RAM_DEPTH = DEPTH - 1;

  localparam logic [AW-1:0] PTR_LAST   = AW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_TH);

  // RAM holds RAM_DEPTH entries, so pointers wrap at RAM_DEPTH-1 rather
  // than at a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              byp_sel_q, byp_sel_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  logic              wr_acc;
  logic              rd_acc;
  logic              single_word;
  logic              head_from_din;
  logic              ram_push;
  logic              ram_pop;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] ram_head;
  fifo_op_e          op;

  // The RAM read port is always aimed at the next-cycle rd_ptr, so the
  // word behind the head is already sitting in the read register when a
  // pop arrives. The only time that registered word is stale is when a
  // push lands on the very address being read (RAM empty after this
  // edge's pop); that push is captured in the bypass register instead.
  assign ram_head = byp_sel_q ? byp_data_q : ram_rd_data;

  always_comb begin
    wr_acc        = wr_en & ~full_q;
    rd_acc        = rd_en & ~empty_q;
    single_word   = (count_q == CNT_ONE);
    // din goes straight to the head when nothing else would be in front
    // of it: FIFO empty, or the single held word is being read out.
    head_from_din = wr_acc & (empty_q | (rd_acc & single_word));
    ram_push      = wr_acc & ~head_from_din;
    ram_pop       = rd_acc & ~single_word;
    op            = fifo_op_e'({wr_acc, rd_acc});

    count_d = count_q;
    case (op)
      OP_WRITE: count_d = count_q + CW'(1);
      OP_READ:  count_d = count_q - CW'(1);
      default:  count_d = count_q;
    endcase

    wr_ptr_d = ram_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = ram_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    head_d = head_q;
    if (head_from_din) begin
      head_d = din;
    end else if (ram_pop) begin
      head_d = ram_head;
    end else if (rd_acc) begin
      // Last word leaves: blank the head so nothing old lingers on dout.
      head_d = '0;
    end

    byp_sel_d  = ram_push & (wr_ptr_q == rd_ptr_d);
    byp_data_d = din;

    empty_d  = (count_d == '0);
    full_d   = (count_d == CNT_FULL);
    afull_d  = (count_d >= AFULL_LVL);
    aempty_d = (count_d <= AEMPTY_LVL);

    overflow_d  = (overflow_q  & ~err_clr) | (wr_en & full_q);
    underflow_d = (underflow_q & ~err_clr) | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      byp_sel_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      byp_sel_q   <= byp_sel_d;
    end
  end

  // Pure datapath: only consulted when byp_sel_q is set.
  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
  end

  keyhash_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_push & rst_n),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  assign dout         = head_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/keyhash_fwft_fifo.md
KEYHASH_FWFT_FIFO -- requirements
Module: keyhash_fwft_fifo

Interface
REQ-001 Parameter DATA_W, default 128, word width in bits.
REQ-002 Parameter DEPTH, default 16, storage depth in words; power of two, 4..1024.
REQ-003 Parameter AFULL_TH, default DEPTH-2, almost_full asserts when count >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 2, almost_empty asserts when count <= AEMPTY_TH.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 din  input  DATA_W  write data.
REQ-009 rd_en  input  1  read/acknowledge of word currently on dout.
REQ-010 dout  output  DATA_W  head word, valid whenever empty=0 (first-word-fall-through).
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  no word on dout.
REQ-013 almost_full  output  1  per REQ-003.
REQ-014 almost_empty  output  1  per REQ-004.
REQ-015 count  output  $clog2(DEPTH)+1  words held, including the head word on dout.
REQ-016 overflow  output  1  sticky: write attempted while full.
REQ-017 underflow  output  1  sticky: read attempted while empty.
REQ-018 err_clr  input  1  clears overflow/underflow on the next edge.

Function
REQ-019 Write accepted iff wr_en=1 and full=0; a write while full is dropped, contents unchanged, overflow set.
REQ-020 Read accepted iff rd_en=1 and empty=0; a read while empty does nothing except set underflow.
REQ-021 FWFT latency: a word written at edge N into an empty FIFO appears on dout, with empty=0, after edge N (one cycle).
REQ-022 After an accepted read at edge N, the next word is on dout after edge N, or empty=1 if none remains.
REQ-023 Head word is held in an output register; the remaining DEPTH-1 words are held in RAM addressed by wrap-around wr_ptr/rd_ptr modulo DEPTH-1 entries plus the head register.
REQ-024 count increments on write-only, decrements on read-only, and is unchanged on simultaneous accepted write and read.
REQ-025 Simultaneous wr_en and rd_en while full: read accepted, write dropped (full evaluated before the edge), overflow set.
REQ-026 Simultaneous wr_en and rd_en while empty: write accepted per REQ-021, underflow set.
REQ-027 Simultaneous wr_en and rd_en with exactly one word held: head replaced by din after the edge, count stays 1, empty stays 0.
REQ-028 full, empty, almost_full, almost_empty are registered and consistent with count at every cycle.
REQ-029 Ordering is strict FIFO; no word is duplicated or lost except writes dropped under REQ-019.
REQ-030 If err_clr and a new error occur in the same cycle, the flag stays set.

Reset
REQ-031 With rst_n=0 at an edge: count=0, pointers=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0.
REQ-032 Reset mid-operation discards all stored words; wr_en/rd_en are ignored while rst_n=0.
REQ-033 RAM contents are not reset; dout never exposes stale RAM while empty=1.

Structure
REQ-034 Package keyhash_pkg holds KEY_W=128, default DEPTH and threshold constants, and a clog2 helper.
REQ-035 Storage is a sub-module keyhash_fifo_ram: simple dual-port RAM, registered write, one-cycle read, inferable as block RAM.
REQ-036 Control (pointers, count, flags, head register) lives in keyhash_fwft_fifo.

Verification
REQ-037 Reset, then write 10 keys 0x1..0xA back-to-back -> dout=0x1 one cycle after first write, count=10, reading 10 returns 0x1..0xA in order, then empty=1.
REQ-038 Fill DEPTH=16, then write 0xDEAD -> full=1, overflow=1, count=16, 0xDEAD never appears on dout; err_clr -> overflow=0.
REQ-039 Empty FIFO, assert rd_en and wr_en=0x55 together -> underflow=1, dout=0x55, count=1.
REQ-040 Continuous simultaneous wr/rd for 3*DEPTH cycles from count=8 -> count constant at 8, pointer wrap, data order preserved.
REQ-041 Sweep count 0..16 -> almost_empty high for count<=2, almost_full high for count>=14.
REQ-042 rst_n=0 asserted with count=9 -> next cycle empty=1, count=0, all flags cleared; subsequent write of 0x77 -> dout=0x77.
